// File: rtl/gate_drv_pkg.sv
// Shared types and width helpers for the gate_drv bridge gate-drive stage.
// The state encoding and default counter sizes are shared by the RTL and its bench.
package gate_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_DEAD    = 3'd2,
    ST_CONDUCT = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int DEAD_MAX_DEF = 255;
  localparam int HALF_MAX_DEF = 4095;

  // Bits needed to hold every value from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEAD_W_DEF = cnt_width(DEAD_MAX_DEF);
  localparam int HALF_W_DEF = cnt_width(HALF_MAX_DEF);

endpackage

// File: rtl/gate_drv_sync.sv
// gate_drv_sync: WIDTH-bit two-flop synchroniser with asynchronous active-high reset.
// Each bit is synchronised independently; no coherency between bits is implied.
module gate_drv_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_drv.sv
// gate_drv: bridge gate-drive FSM producing non-overlapping diagonal gate commands with dead time.
// Define GATE_DRV_OCD_LATCH_EN to make FAULT sticky until rst.
module gate_drv
  import gate_drv_pkg::*;
#(
  parameter  int DEAD_MAX = DEAD_MAX_DEF,
  parameter  int HALF_MAX = HALF_MAX_DEF,
  localparam int DW       = cnt_width(DEAD_MAX),
  localparam int HW       = cnt_width(HALF_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sgn_pre,
  input  logic          en,
  input  logic          ocd,
  input  logic [DW-1:0] dead,
  input  logic [HW-1:0] on_max,
  output logic          gate_p,
  output logic          gate_n,
  output logic          active,
  output logic          fault
);

  localparam logic [HW-1:0] HALF_SAT = HW'(HALF_MAX);

  logic [1:0] sync_out;
  logic       en_s;
  logic       ocd_s;

  gate_drv_sync #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({en, ocd}),
    .q   (sync_out)
  );

  assign en_s  = sync_out[1];
  assign ocd_s = sync_out[0];

  state_t        state_q,    state_d;
  logic          sgn_prev_q, sgn_prev_d;
  logic          en_prev_q,  en_prev_d;
  logic [DW-1:0] dcnt_q,     dcnt_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          gate_p_q,   gate_p_d;
  logic          gate_n_q,   gate_n_d;
  logic          active_q,   active_d;
  logic          fault_q,    fault_d;

  logic          sgn_edge;
  logic          en_rise;
  logic [HW:0]   half_inc;
  logic          stop_burst;
  logic          load_gate;

  assign sgn_edge   = sgn_pre ^ sgn_prev_q;
  assign en_rise    = en_s & ~en_prev_q;
  assign half_inc   = {1'b0, half_cnt_q} + {{HW{1'b0}}, 1'b1};
  // The extra bit in half_inc keeps the limit compare correct when on_max equals HALF_MAX.
  assign stop_burst = ~en_s | ((on_max != '0) && (half_inc >= {1'b0, on_max}));

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    half_cnt_d = half_cnt_q;
    load_gate  = 1'b0;
    sgn_prev_d = sgn_pre;
    en_prev_d  = en_s;

    if (ocd_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_rise) begin
            state_d = ST_ARM;
          end
        end

        ST_ARM: begin
          if (!en_s) begin
            state_d = ST_IDLE;
          end else if (sgn_edge) begin
            half_cnt_d = '0;
            dcnt_d     = dead;
            if (dead == '0) begin
              state_d   = ST_CONDUCT;
              load_gate = 1'b1;
            end else begin
              state_d = ST_DEAD;
            end
          end
        end

        ST_DEAD, ST_CONDUCT: begin
          // Bursts only ever stop or turn around at a feedback zero crossing.
          if (sgn_edge) begin
            half_cnt_d = (half_cnt_q == HALF_SAT) ? half_cnt_q : half_inc[HW-1:0];
            if (stop_burst) begin
              state_d = ST_IDLE;
            end else begin
              dcnt_d = dead;
              if (dead == '0) begin
                state_d   = ST_CONDUCT;
                load_gate = 1'b1;
              end else begin
                state_d = ST_DEAD;
              end
            end
          end else if (state_q == ST_DEAD) begin
            if (dcnt_q <= DW'(1)) begin
              state_d   = ST_CONDUCT;
              load_gate = 1'b1;
              dcnt_d    = '0;
            end else begin
              dcnt_d = dcnt_q - DW'(1);
            end
          end
        end

        ST_FAULT: begin
`ifdef GATE_DRV_OCD_LATCH_EN
          state_d = ST_FAULT;
`else
          if (!en_s) begin
            state_d = ST_IDLE;
          end
`endif
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Gate polarity is captured only on entry to CONDUCT, so the pair stays complementary.
  always_comb begin
    gate_p_d = 1'b0;
    gate_n_d = 1'b0;
    if (state_d == ST_CONDUCT) begin
      if (load_gate) begin
        gate_p_d = sgn_pre;
        gate_n_d = ~sgn_pre;
      end else begin
        gate_p_d = gate_p_q;
        gate_n_d = gate_n_q;
      end
    end
    active_d = (state_d == ST_DEAD) || (state_d == ST_CONDUCT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sgn_prev_q <= 1'b0;
      en_prev_q  <= 1'b0;
      dcnt_q     <= '0;
      half_cnt_q <= '0;
      gate_p_q   <= 1'b0;
      gate_n_q   <= 1'b0;
      active_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sgn_prev_q <= sgn_prev_d;
      en_prev_q  <= en_prev_d;
      dcnt_q     <= dcnt_d;
      half_cnt_q <= half_cnt_d;
      gate_p_q   <= gate_p_d;
      gate_n_q   <= gate_n_d;
      active_q   <= active_d;
      fault_q    <= fault_d;
    end
  end

  assign gate_p = gate_p_q;
  assign gate_n = gate_n_q;
  assign active = active_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_gate_drv.sv
// Bench for gate_drv: randomized sgn_pre half-periods plus directed en/ocd/rst events,
// checked every cycle against a burst-level model (edge times, dead delay, half-cycle count).
module tb_gate_drv;
  import gate_drv_pkg::*;

  localparam int DW = DEAD_W_DEF;
  localparam int HW = HALF_W_DEF;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_BURST = 2;
  localparam int M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sgn_pre;
  logic          en;
  logic          ocd;
  logic [DW-1:0] dead;
  logic [HW-1:0] on_max;
  logic          gate_p;
  logic          gate_n;
  logic          active;
  logic          fault;

  int vectors     = 0;
  int miscompares = 0;

  int cyc = 0;
  int mode;
  int halves;
  int start_cyc;
  int dly;
  bit pol;
  bit m_en1, m_en2, m_ocd1, m_ocd2, m_sgn, m_en_prev;
  bit exp_p, exp_n, exp_act, exp_flt;

  int half_lo, half_hi, sgn_cnt, since_edge;
  int p_rises, n_rises;
  bit last_p, last_n;
  bit latch_build;

  gate_drv dut (
    .clk     (clk),
    .rst     (rst),
    .sgn_pre (sgn_pre),
    .en      (en),
    .ocd     (ocd),
    .dead    (dead),
    .on_max  (on_max),
    .gate_p  (gate_p),
    .gate_n  (gate_n),
    .active  (active),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkOutput();
    compare("gate_p", {31'b0, gate_p}, {31'b0, exp_p});
    compare("gate_n", {31'b0, gate_n}, {31'b0, exp_n});
    compare("active", {31'b0, active}, {31'b0, exp_act});
    compare("fault", {31'b0, fault}, {31'b0, exp_flt});
    compare("no_overlap", {31'b0, gate_p & gate_n}, 32'd0);
  endtask

  task automatic model_reset();
    mode = M_OFF;
    halves = 0;
    start_cyc = 0;
    dly = 0;
    pol = 1'b0;
    m_en1 = 1'b0; m_en2 = 1'b0;
    m_ocd1 = 1'b0; m_ocd2 = 1'b0;
    m_sgn = 1'b0; m_en_prev = 1'b0;
    exp_p = 1'b0; exp_n = 1'b0; exp_act = 1'b0; exp_flt = 1'b0;
  endtask

  // A half-cycle starts at the edge; its gate is lit once dly clocks have elapsed.
  task automatic start_half();
    start_cyc = cyc;
    dly = int'(dead);
    pol = sgn_pre;
  endtask

  task automatic model_step();
    bit en_s, ocd_s, sedge, rise;
    bit lit;
    en_s  = m_en2;
    ocd_s = m_ocd2;
    sedge = sgn_pre ^ m_sgn;
    rise  = en_s & ~m_en_prev;
    cyc++;
    if (mode == M_FAULT) begin
      if (!latch_build && !en_s && !ocd_s) mode = M_OFF;
    end else if (ocd_s) begin
      mode = M_FAULT;
    end else if (mode == M_OFF) begin
      if (rise) mode = M_ARMED;
    end else if (mode == M_ARMED) begin
      if (!en_s) mode = M_OFF;
      else if (sedge) begin
        mode = M_BURST;
        halves = 0;
        start_half();
      end
    end else if (sedge) begin
      if (!en_s || (int'(on_max) != 0 && halves + 1 >= int'(on_max))) mode = M_OFF;
      else begin
        halves++;
        start_half();
      end
    end
    m_en2 = m_en1;  m_en1 = en;
    m_ocd2 = m_ocd1; m_ocd1 = ocd;
    m_sgn = sgn_pre;
    m_en_prev = en_s;
    exp_act = (mode == M_BURST);
    exp_flt = (mode == M_FAULT);
    lit     = exp_act && (cyc - start_cyc >= dly);
    exp_p   = lit && pol;
    exp_n   = lit && !pol;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      since_edge++;
      if (sgn_cnt <= 1) begin
        sgn_pre = ~sgn_pre;
        sgn_cnt = $urandom_range(half_hi, half_lo);
        since_edge = 0;
      end else begin
        sgn_cnt--;
      end
      @(posedge clk);
      #1;
      model_step();
      checkOutput();
      if (gate_p && !last_p) p_rises++;
      if (gate_n && !last_n) n_rises++;
      last_p = gate_p;
      last_n = gate_n;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    ocd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_p = 1'b0;
    last_n = 1'b0;
    checkOutput();
  endtask

  initial begin
`ifdef GATE_DRV_OCD_LATCH_EN
    latch_build = 1'b1;
`else
    latch_build = 1'b0;
`endif
    rst = 1'b1; sgn_pre = 1'b0; en = 1'b0; ocd = 1'b0;
    dead = DW'(4); on_max = '0;
    half_lo = 50; half_hi = 50; sgn_cnt = 10; since_edge = 0;
    p_rises = 0; n_rises = 0;
    model_reset();
    do_reset();

    $display("[TB] free-running burst, dead=4, then en drops mid half-cycle");
    en = 1'b1;
    applyStimulus(300);
    for (int i = 0; i < 200 && !(exp_act && since_edge == 20); i++) applyStimulus(1);
    en = 1'b0;
    applyStimulus(80);
    compare("stopped_after_en_low", {31'b0, active}, 32'd0);

    $display("[TB] on_max=6 burst with random half-periods");
    dead = DW'(3); on_max = HW'(6); half_lo = 8; half_hi = 20;
    p_rises = 0; n_rises = 0;
    en = 1'b1;
    applyStimulus(250);
    compare("burst_p_pulses", p_rises, 32'd3);
    compare("burst_n_pulses", n_rises, 32'd3);
    applyStimulus(200);
    compare("no_restart_level_en", p_rises + n_rises, 32'd6);
    en = 1'b0;
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(200);

    $display("[TB] ocd pulse mid-conduct");
    en = 1'b0; dead = DW'(2); on_max = '0; half_lo = 40; half_hi = 40;
    applyStimulus(10);
    en = 1'b1;
    for (int i = 0; i < 300 && !(exp_act && since_edge == 15); i++) applyStimulus(1);
    ocd = 1'b1;
    applyStimulus(1);
    ocd = 1'b0;
    applyStimulus(2);
    compare("ocd_gates_off", {31'b0, gate_p | gate_n}, 32'd0);
    compare("ocd_fault", {31'b0, fault}, 32'd1);
    applyStimulus(20);
    en = 1'b0;
    applyStimulus(20);
    compare("fault_after_en_low", {31'b0, fault}, {31'b0, latch_build});
    do_reset();

    $display("[TB] dead=0 then dead=60 against a 50-cycle half-period");
    dead = '0; on_max = '0; half_lo = 50; half_hi = 50;
    en = 1'b1;
    applyStimulus(250);
    dead = DW'(60);
    applyStimulus(200);
    en = 1'b0;
    applyStimulus(60);
    on_max = HW'(3);
    p_rises = 0; n_rises = 0;
    en = 1'b1;
    applyStimulus(260);
    compare("dead60_no_gates", p_rises + n_rises, 32'd0);
    compare("dead60_halves_stop", {31'b0, active}, 32'd0);

    $display("[TB] asynchronous reset mid-conduct");
    do_reset();
    dead = DW'(2); on_max = '0; half_lo = 30; half_hi = 30;
    en = 1'b1;
    for (int i = 0; i < 200 && !(exp_p || exp_n); i++) applyStimulus(1);
    applyStimulus(3);
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst_gate_p", {31'b0, gate_p}, 32'd0);
    compare("async_rst_gate_n", {31'b0, gate_n}, 32'd0);
    compare("async_rst_active", {31'b0, active}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_p = 1'b0; last_n = 1'b0;
    checkOutput();
    applyStimulus(40);
    en = 1'b1;
    applyStimulus(150);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 4; r++) begin
      do_reset();
      dead = DW'($urandom_range(6, 0));
      on_max = HW'($urandom_range(5, 0));
      half_lo = 3; half_hi = 12;
      en = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(39, 0) == 0) en = ~en;
        ocd = ($urandom_range(249, 0) == 0);
        applyStimulus(1);
        ocd = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
